spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//   SPI responder (mode 0: CPOL=0, CPHA=0, MSB first). It is the far end of our spi_ctrl master.
//   sck, cs_n and mosi are oversampled in the sys_clk domain, and each complete word is returned on rx_data.
//   The reply word comes from a one-entry tx holding register, filled through a valid/ready handshake.
//   It sits at the chip-side boundary. The top level builds the miso tristate from miso/miso_oe.
// PARAMETERS
//   DATA_W       8     bits per SPI word
//   SYNC_STAGES  2     synchronizer flops on sck/cs_n/mosi (>=2)
//   IDLE_FILL    8'hFF word shifted out on tx underrun (width DATA_W)
// PORTS
//   sys_clk      in   1       system clock; must run >= 8x the sck frequency
//   sys_rst      in   1       synchronous, active-high reset
//   sck          in   1       SPI clock from master (asynchronous)
//   cs_n         in   1       chip select, active low (asynchronous)
//   mosi         in   1       master-out data (asynchronous)
//   miso         out  1       slave-out data; 0 when not selected
//   miso_oe      out  1       miso output enable; high only while selected
//   tx_data      in   DATA_W  reply word to load into holding register
//   tx_valid     in   1       tx_data offered
//   tx_ready     out  1       holding register empty; accept when tx_valid&tx_ready
//   rx_data      out  DATA_W  last complete received word; held until next word
//   rx_valid     out  1       1-cycle pulse: rx_data updated
//   tx_underrun  out  1       1-cycle pulse: a word load found the holding register empty
//   busy         out  1       frame in progress (synchronized cs_n low)
// BEHAVIOUR
//   Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0.
//   Reset also clears the holding register, shift registers and bit counter, and forces IDLE.
//     This applies mid-frame as well: the partial word is dropped and no pulses are generated.
//   All three inputs pass through SYNC_STAGES flops, so their edges stay mutually aligned.
//     Edges are detected from the last sync stage versus one extra flop.
//   FSM states:
//     IDLE:  cs_n fall -> LOAD.
//     LOAD:  one cycle; moves holding->tx shift reg; drives MSB on miso; miso_oe=1; -> SHIFT.
//     SHIFT: on cs_n rise -> IDLE.
//   In SHIFT, on an sck rising edge:
//     Sample mosi into the rx shift register and increment bit_cnt.
//     When bit_cnt reaches DATA_W: next cycle rx_data={shift,mosi}, rx_valid=1; bit_cnt -> 0.
//   In SHIFT, on an sck falling edge:
//     bit_cnt!=0: shift tx left and drive the next bit.
//     bit_cnt==0 (word boundary): reload tx shift from holding and drive its MSB.
//   Word load (in LOAD or at a boundary):
//     Holding empty -> load IDLE_FILL and pulse tx_underrun the same cycle.
//     Holding full -> load it and set tx_ready=1 next cycle.
//     No bypass: a word written in the load cycle itself stays in holding for the next word.
//   tx_ready = holding empty. A write while full is impossible by the handshake, and is ignored if attempted.
//   cs_n rise mid-word: partial rx bits discarded, no rx_valid, bit_cnt=0.
//     A tx word already loaded is lost; the holding register is untouched.
//   cs_n rise: miso_oe=0 and miso=0 on the cycle after the synchronized edge.
//   sck edges while cs_n is high are ignored.
//   Latency:
//     cs_n fall -> MSB on miso: SYNC_STAGES+2 sys_clk.
//     last sck rise -> rx_valid: SYNC_STAGES+2 sys_clk.
//   Bit counter width: $clog2(DATA_W+1); it never wraps past DATA_W.
// STRUCTURE
//   spi_pkg: state encoding (IDLE/LOAD/SHIFT), default DATA_W, IDLE_FILL default constant.
//   Sub-module spi_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs.
//     Instantiated 3x, for sck, cs_n and mosi (mosi ignores the edge outputs).
//   Top-level: FSM, bit counter, rx/tx shift registers, holding register, handshake.
// TESTING (bench master: mode 0, sck = sys_clk/8, sys_clk period 4ns)
//   1. Assert sys_rst for 5 cycles -> miso_oe=0, miso=0, tx_ready=1, rx_valid=0, busy=0.
//   2. Write 0xA5, then master sends 0x3C in one frame:
//      -> miso bits 1,0,1,0,0,1,0,1; one rx_valid with rx_data=0x3C; no tx_underrun; tx_ready=1 after load.
//   3. Write 0x12; during byte 1 write 0x34; master sends 0x55,0xAA in one 16-bit frame:
//      -> miso 0x12 then 0x34; rx_valid twice (0x55, 0xAA); no underrun.
//   4. No write; master sends 0xC3:
//      -> miso 0xFF; tx_underrun pulses once at LOAD; rx_data=0xC3.
//   5. cs_n rises after 5 sck pulses, then a new full frame sends 0x81:
//      -> no rx_valid for the aborted frame; next rx_data=0x81, bits aligned.
//   6. sys_rst asserted after 3 bits with holding full:
//      -> reset values restored, tx_ready=1; the following frame with a new write 0x7E is received and replied correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM encoding and default widths/fill word.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } spi_state_t;

   localparam int         DEFAULT_DATA_W    = 8;
   localparam logic [7:0] DEFAULT_IDLE_FILL = 8'hFF;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with edge pulses taken
// from the last stage against one extra delay flop.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              prev_q;
   logic              prev_d;

   // Shift the pin through the chain; the delay flop trails the last stage.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      prev_d = sync_q[STAGES-1];
   end

   // Chain registers; reset to the pin's idle level so no false edge follows reset.
   always_ff @(posedge clk) begin
      if (srst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign dout = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule : spi_sync

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sck/cs_n/mosi, returns each received word on
// rx_data and replies from a one-entry holding register filled by valid/ready.
module spi_slave
   import spi_pkg::*;
#(
   parameter int                DATA_W      = DEFAULT_DATA_W,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] IDLE_FILL   = DATA_W'(DEFAULT_IDLE_FILL)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_underrun,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic sck_s, sck_rise, sck_fall;
   logic cs_n_s, cs_rise_unused, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk  (sys_clk),
      .srst (sys_rst),
      .din  (sck),
      .dout (sck_s),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk  (sys_clk),
      .srst (sys_rst),
      .din  (cs_n),
      .dout (cs_n_s),
      .rise (cs_rise_unused),
      .fall (cs_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk  (sys_clk),
      .srst (sys_rst),
      .din  (mosi),
      .dout (mosi_s),
      .rise (mosi_rise_unused),
      .fall (mosi_fall_unused)
   );

   spi_state_t        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              underrun_q, underrun_d;
   logic              miso_q, miso_d;
   logic              miso_oe_q, miso_oe_d;
   logic              load_word;
   logic [DATA_W-1:0] load_val;

   // Next-state logic: frame FSM, bit counting, shifting, word loads and the tx handshake.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      miso_d      = miso_q;
      miso_oe_d   = miso_oe_q;
      load_word   = 1'b0;
      load_val    = IDLE_FILL;

      case (state_q)
         ST_IDLE: begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            bit_cnt_d = '0;
            if (cs_fall) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_word  = 1'b1;
            miso_oe_d  = 1'b1;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            state_d    = ST_SHIFT;
         end
         ST_SHIFT: begin
            // A full word is published one cycle after its last bit was sampled.
            if (bit_cnt_q == CNT_W'(DATA_W)) begin
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               bit_cnt_d  = '0;
            end
            if (cs_n_s) begin
               // Deselect: drop any partial word and release the line.
               state_d    = ST_IDLE;
               miso_d     = 1'b0;
               miso_oe_d  = 1'b0;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
               if (bit_cnt_q != CNT_W'(DATA_W)) begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (sck_fall) begin
               if (bit_cnt_q != '0) begin
                  tx_shift_d = tx_shift_q << 1;
                  miso_d     = tx_shift_q[DATA_W-2];
               end else begin
                  load_word = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A word load consumes the holding register, or the fill word on underrun.
      if (load_word) begin
         if (hold_full_q) begin
            load_val    = hold_q;
            hold_full_d = 1'b0;
         end else begin
            load_val   = IDLE_FILL;
            underrun_d = 1'b1;
         end
         tx_shift_d = load_val;
         miso_d     = load_val[DATA_W-1];
      end

      // Writes only land in an empty register; a write in a load cycle is kept for the next word.
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = underrun_q;
   assign busy        = ~cs_n_s;

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 master at sys_clk/8, a queue model
// of the reply holding register, table vectors, random words and corner sequences.
module tb_spi_slave;

   logic       sys_clk;
   logic       sys_rst;
   logic       sck;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rxq[$];
   int         under_cnt = 0;
   logic [7:0] model_hold[$];

   spi_slave dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .sck         (sck),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underrun (tx_underrun),
      .busy        (busy)
   );

   initial sys_clk = 1'b0;
   always #2 sys_clk = ~sys_clk;

   // Collect received words and underrun pulses away from the active edge.
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (rx_valid) rxq.push_back(rx_data);
         if (tx_underrun) under_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model of the reply path: a word load takes the oldest written word, else the fill.
   function automatic logic [8:0] model_load();
      if (model_hold.size() > 0) return {1'b0, model_hold.pop_front()};
      return {1'b1, 8'hFF};
   endfunction

   task automatic write_word(input logic [7:0] d);
      bit done;
      done = 1'b0;
      @(negedge sys_clk);
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         if (tx_ready) begin
            @(posedge sys_clk);
            done = 1'b1;
         end else begin
            @(negedge sys_clk);
         end
      end
      #1 tx_valid = 1'b0;
      chk("write_accept", 32'(done), 32'd1);
   endtask

   // Mode-0 master: data changes with sck fall, miso is captured just before sck rises.
   // The last falling edge coincides with the cs_n rise.
   task automatic spi_xfer(input logic [15:0] mo, input int n, output logic [15:0] mi);
      mi = '0;
      @(negedge sys_clk);
      cs_n = 1'b0;
      mosi = mo[n-1];
      repeat (8) @(negedge sys_clk);
      for (int b = 0; b < n; b++) begin
         mi  = {mi[14:0], miso};
         sck = 1'b1;
         repeat (4) @(negedge sys_clk);
         sck = 1'b0;
         if (b == n - 1) cs_n = 1'b1;
         else            mosi = mo[n-2-b];
         repeat (4) @(negedge sys_clk);
      end
      mosi = 1'b0;
      repeat (8) @(negedge sys_clk);
   endtask

   task automatic run_word(input bit wr, input logic [7:0] txw, input logic [7:0] mw,
                           input logic [7:0] exp_mi, input logic [7:0] exp_rx,
                           input int exp_u, input string tag);
      int          rx0, u0;
      logic [15:0] mi;
      rx0 = rxq.size();
      u0  = under_cnt;
      if (wr) write_word(txw);
      spi_xfer({8'h00, mw}, 8, mi);
      chk({tag, "_miso"}, 32'(mi[7:0]), 32'(exp_mi));
      chk({tag, "_rx_count"}, 32'(rxq.size() - rx0), 32'd1);
      chk({tag, "_rx_data"}, (rxq.size() > 0) ? 32'(rxq[$]) : 32'hDEAD, 32'(exp_rx));
      chk({tag, "_underruns"}, 32'(under_cnt - u0), 32'(exp_u));
      chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
      chk({tag, "_oe_after"}, {30'd0, miso_oe, miso}, 32'd0);
      $display("frame %s wr=%0d tx=%h mosi=%h miso=%h rx=%h", tag, wr, txw, mw, mi[7:0],
               (rxq.size() > 0) ? rxq[$] : 8'h00);
   endtask

   typedef struct {
      bit         wr;
      logic [7:0] tx;
      logic [7:0] mo;
      logic [7:0] exp_mi;
      logic [7:0] exp_rx;
      int         exp_u;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [15:0] mi16;
      logic [8:0]  ld;
      int          rx0, u0;
      bit          wr;
      logic [7:0]  txw, mw;

      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
      vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'hFF, 8'hC3, 1};
      vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
      vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 0};

      sys_rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tx_data = '0; tx_valid = 1'b0;
      repeat (5) @(negedge sys_clk);
      chk("rst_miso", 32'(miso), 32'd0);
      chk("rst_miso_oe", 32'(miso_oe), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_underrun", 32'(tx_underrun), 32'd0);
      sys_rst = 1'b0;
      repeat (4) @(negedge sys_clk);

      // Table vectors with hand-computed expectations.
      for (int i = 0; i < 4; i++) begin
         run_word(vecs[i].wr, vecs[i].tx, vecs[i].mo, vecs[i].exp_mi, vecs[i].exp_rx,
                  vecs[i].exp_u, $sformatf("vec%0d", i));
      end

      // Two-word frame with the second reply written during the first word.
      rx0 = rxq.size();
      u0  = under_cnt;
      write_word(8'h12);
      fork
         spi_xfer(16'h55AA, 16, mi16);
         begin
            repeat (20) @(negedge sys_clk);
            write_word(8'h34);
         end
      join
      chk("two_word_miso", 32'(mi16), 32'h1234);
      chk("two_word_rx_count", 32'(rxq.size() - rx0), 32'd2);
      chk("two_word_rx0", (rxq.size() >= 2) ? 32'(rxq[$-1]) : 32'hDEAD, 32'h55);
      chk("two_word_rx1", (rxq.size() >= 1) ? 32'(rxq[$]) : 32'hDEAD, 32'hAA);
      chk("two_word_underruns", 32'(under_cnt - u0), 32'd0);
      $display("frame two_word mosi=55AA miso=%h", mi16);

      // Aborted frame after 5 bits, then a clean frame.
      rx0 = rxq.size();
      u0  = under_cnt;
      spi_xfer(16'h0016, 5, mi16);
      chk("abort_rx_count", 32'(rxq.size() - rx0), 32'd0);
      chk("abort_underruns", 32'(under_cnt - u0), 32'd1);
      chk("abort_miso", 32'(mi16), 32'h001F);
      $display("frame abort bits=5 miso=%h", mi16[4:0]);
      run_word(1'b1, 8'h42, 8'h81, 8'h42, 8'h81, 0, "after_abort");

      // Reset in the middle of a frame with the holding register full.
      rx0 = rxq.size();
      u0  = under_cnt;
      write_word(8'h11);
      @(negedge sys_clk);
      cs_n = 1'b0;
      mosi = 1'b1;
      repeat (8) @(negedge sys_clk);
      for (int b = 0; b < 3; b++) begin
         sck = 1'b1;
         repeat (4) @(negedge sys_clk);
         sck  = 1'b0;
         mosi = b[0];
         repeat (4) @(negedge sys_clk);
      end
      write_word(8'h22);
      chk("midrst_full", 32'(tx_ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_oe", 32'(miso_oe), 32'd1);
      @(negedge sys_clk);
      sys_rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      repeat (5) @(negedge sys_clk);
      chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
      chk("midrst_rst_oe", {30'd0, miso_oe, miso}, 32'd0);
      chk("midrst_rst_busy", 32'(busy), 32'd0);
      chk("midrst_rx_data", 32'(rx_data), 32'd0);
      sys_rst = 1'b0;
      repeat (4) @(negedge sys_clk);
      chk("midrst_rx_count", 32'(rxq.size() - rx0), 32'd0);
      chk("midrst_underruns", 32'(under_cnt - u0), 32'd0);
      $display("frame midrst bits=3 reset applied");
      run_word(1'b1, 8'h7E, 8'h5A, 8'h7E, 8'h5A, 0, "post_rst");

      // Random single-word frames checked against the holding-register model.
      for (int i = 0; i < 16; i++) begin
         wr  = 1'($urandom_range(0, 1));
         txw = 8'($urandom);
         mw  = 8'($urandom);
         if (wr) model_hold.push_back(txw);
         ld = model_load();
         run_word(wr, txw, mw, ld[7:0], mw, int'(ld[8]), $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_spi_slave
